dma_peripheral_port: RTL and testbench
======================================

DMA_PERIPHERAL_PORT -- requirements
Module: dma_peripheral_port

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, 2..16)
- DREQ_ACTIVE_HIGH, 1, DREQ polarity
- DACK_ACTIVE_HIGH, 0, DACK polarity
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports (name, direction, width, meaning):
- CLK, in, 1, single clock
- RESET, in, 1, asynchronous active-low reset
- DREQ, out, 1, DMA request to controller
- DACK, in, 1, DMA acknowledge from controller
- IOR_N, in, 1, I/O read strobe (device-to-memory)
- IOW_N, in, 1, I/O write strobe (memory-to-device)
- EOP_N_IN, in, 1, end of process from controller
- EOP_N_OUT, out, 1, device-forced end of process
- DB_IN, in, 8, data bus from controller side
- DB_OUT, out, 8, data bus to controller side
- DB_OE, out, 1, DB_OUT drive enable
- enable, in, 1, local DMA enable
- dir, in, 1, 1 = device-to-memory (IOR), 0 = memory-to-device (IOW)
- push_valid / push_data / push_ready, in / in 8 / out, local bytes into FIFO (dir=1)
- pop_valid / pop_data / pop_ready, out / out 8 / in, local bytes out of FIFO (dir=0)
- stop_req, in, 1, assert EOP on next strobe
- tc_flag / ovr_flag / udr_flag, out, 1 each, sticky status
- flag_clr, in, 1, clears flags and leaves TERM

Function
REQ-003 All inputs SHALL be synchronous to CLK; a strobe "completes" on the first CLK edge where the registered previous IOR_N/IOW_N is 0 and the current value is 1.
REQ-004 "DACK active" SHALL mean DACK equals DACK_ACTIVE_HIGH; the asserted DREQ level SHALL be DREQ_ACTIVE_HIGH.
REQ-005 The FSM SHALL have states IDLE, REQ, SERVICE and TERM.
REQ-006 IDLE->REQ SHALL occur when enable=1 and ready holds, where ready = (count>=1) for dir=1 and (count<FIFO_DEPTH) for dir=0.
REQ-007 DREQ SHALL be asserted (registered) in REQ and SERVICE only.
REQ-008 REQ->SERVICE SHALL occur on DACK active; REQ->IDLE SHALL occur when enable=0 or ready=0 before DACK.
REQ-009 SERVICE->IDLE SHALL occur when ready=0 or enable=0, with DREQ deasserted on the next edge; an in-progress strobe SHALL still complete.
REQ-010 dir SHALL be latched only in IDLE; changes in other states SHALL be ignored.
REQ-011 For dir=1, while DACK is active and IOR_N=0, DB_OE SHALL be 1 and DB_OUT SHALL be the FIFO head; otherwise DB_OE=0 and DB_OUT=0x00.
REQ-012 For dir=1, strobe completion SHALL pop one byte; if the FIFO is empty, udr_flag SHALL be set, DB_OUT=0x00 and no pop occurs.
REQ-013 For dir=0, strobe completion SHALL write the DB_IN value sampled on the last cycle IOW_N=0 into the FIFO; if the FIFO is full, ovr_flag SHALL be set and the byte dropped.
REQ-014 Strobes without DACK active, or strobes of the wrong type for dir, SHALL be ignored.
REQ-015 push_ready SHALL be (count<FIFO_DEPTH && dir==1); pop_valid SHALL be (count>0 && dir==0); pop_data SHALL be the FIFO head.
REQ-016 A local transfer and a DMA transfer in the same cycle SHALL leave count unchanged; count SHALL be 0..FIFO_DEPTH with wrap-around pointers.
REQ-017 If stop_req is seen (held pending) and the next strobe occurs, EOP_N_OUT SHALL be 0 for that strobe's low phase; otherwise EOP_N_OUT=1.
REQ-018 EOP_N_IN=0 with DACK active, or a device-forced EOP strobe completing, SHALL set tc_flag and move the FSM to TERM.
REQ-019 In TERM, DREQ SHALL be 0 and the FSM SHALL leave only on flag_clr, going to IDLE; FIFO contents SHALL be kept.
REQ-020 flag_clr SHALL clear all three flags; a set event in the same cycle SHALL win.

Reset
REQ-021 RESET=0 SHALL asynchronously force: state IDLE, DREQ inactive, DB_OE=0, DB_OUT=0x00, EOP_N_OUT=1, FIFO empty, flags 0, dir latch 1, stop pending 0; this holds even mid-strobe.

Verification
REQ-022 Scenario 1: dir=1, push 0xA5, enable=1, DACK active, IOR_N low 2 cycles then high -> DREQ high within 2 cycles, DB_OUT=0xA5 with DB_OE=1 during the strobe, count 0, DREQ drops.
REQ-023 Scenario 2: dir=0, DB_IN=0x3C during an IOW_N pulse with DACK -> pop_valid=1, pop_data=0x3C.
REQ-024 Scenario 3: dir=0, FIFO full, fifth IOW strobe -> ovr_flag=1, DREQ low, contents unchanged.
REQ-025 Scenario 4: EOP_N_IN=0 during a DACK strobe -> tc_flag=1, state TERM, DREQ held low despite ready, until flag_clr.
REQ-026 Scenario 5: stop_req pulse, then IOR strobe -> EOP_N_OUT low during the strobe, tc_flag=1.
REQ-027 Scenario 6: RESET low mid-IOR with 3 bytes queued -> DB_OE=0, DREQ inactive, count 0 immediately.

Source files
------------

// File: rtl/dma_peripheral_port.sv
// -----------------------------------------------------------------------------
// dma_peripheral_port
//
// Peripheral side of an 8237-style DMA handshake. A small byte FIFO sits
// between the local logic and the DMA data bus.
//   dir=1 (device-to-memory): local logic pushes bytes, and the controller
//         reads them with IOR_N strobes.
//   dir=0 (memory-to-device): the controller writes bytes with IOW_N strobes,
//         and local logic pops them.
// DREQ is raised while the FIFO can service a transfer. The end of a
// transfer is reported through sticky status flags and the TERM state.
//
// Ports
//   CLK, RESET          clock, asynchronous active-low reset
//   DREQ / DACK         request to / acknowledge from controller (polarity
//                       set by parameters)
//   IOR_N, IOW_N        I/O read / write strobes (active low)
//   EOP_N_IN            controller end of process (active low)
//   EOP_N_OUT           device-forced end of process (active low)
//   DB_IN / DB_OUT      controller-side data bus in / out
//   DB_OE               DB_OUT drive enable
//   enable, dir         local DMA enable, transfer direction
//   push_*              local byte input into FIFO (dir=1)
//   pop_*               local byte output from FIFO (dir=0)
//   stop_req            request EOP on the next strobe
//   tc_flag, ovr_flag,  sticky terminal-count / overrun / underrun flags
//   udr_flag
//   flag_clr            clear flags and leave TERM
// -----------------------------------------------------------------------------
module dma_peripheral_port #(
    parameter int FIFO_DEPTH       = 4,
    parameter bit DREQ_ACTIVE_HIGH = 1'b1,
    parameter bit DACK_ACTIVE_HIGH = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic       EOP_N_IN,
    output logic       EOP_N_OUT,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    input  logic       enable,
    input  logic       dir,
    input  logic       push_valid,
    input  logic [7:0] push_data,
    output logic       push_ready,
    output logic       pop_valid,
    output logic [7:0] pop_data,
    input  logic       pop_ready,
    input  logic       stop_req,
    output logic       tc_flag,
    output logic       ovr_flag,
    output logic       udr_flag,
    input  logic       flag_clr
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE,
        S_TERM
    } state_t;

    state_t          state_q, state_d;
    logic            dreq_q;
    logic            dir_q;
    logic            ior_act_q;
    logic            iow_act_q;
    logic [7:0]      db_lat_q;
    logic            stop_pend_q, stop_pend_d;
    logic            tc_q, tc_d;
    logic            ovr_q, ovr_d;
    logic            udr_q, udr_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic            dack_act;
    logic            ior_done, iow_done;
    logic            strobe_low;
    logic            fifo_empty, fifo_full;
    logic            ready;
    logic            push_acc, pop_acc;
    logic            dma_rd, dma_wr;
    logic            fifo_wr, fifo_rd;
    logic [7:0]      wr_data;
    logic [7:0]      head;
    logic            forced_eop;
    logic            eop_event;
    logic            db_oe;
    logic [7:0]      mem_rd [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign dack_act = (DACK == DACK_ACTIVE_HIGH);

    // A strobe only counts if DACK was active during its last low cycle;
    // it completes on the rising edge of the strobe, and only the strobe
    // type matching the latched direction is honoured.
    assign ior_done   = dir_q  && ior_act_q && IOR_N;
    assign iow_done   = !dir_q && iow_act_q && IOW_N;
    assign strobe_low = dack_act && (dir_q ? !IOR_N : !IOW_N);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign ready      = dir_q ? !fifo_empty : !fifo_full;

    assign push_ready = dir_q && !fifo_full;
    assign pop_valid  = !dir_q && !fifo_empty;
    assign pop_data   = head;

    assign push_acc = push_valid && push_ready;
    assign pop_acc  = pop_valid && pop_ready;
    assign dma_rd   = ior_done && !fifo_empty;
    assign dma_wr   = iow_done && !fifo_full;

    // Only one writer and one reader can be active per direction.
    assign fifo_wr = push_acc || dma_wr;
    assign fifo_rd = dma_rd || pop_acc;
    assign wr_data = dir_q ? push_data : db_lat_q;

    assign forced_eop = stop_pend_q && (ior_done || iow_done);
    assign eop_event  = (!EOP_N_IN && dack_act) || forced_eop;

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    // Combinational, so the bus follows the strobe without a cycle of lag.
    // RESET gates the output so that the bus is released at once, even
    // mid-strobe.
    assign db_oe     = RESET && dir_q && dack_act && !IOR_N;
    assign DB_OE     = db_oe;
    assign DB_OUT    = (db_oe && !fifo_empty) ? head : 8'h00;
    assign EOP_N_OUT = !(stop_pend_q && strobe_low);
    assign DREQ      = DREQ_ACTIVE_HIGH ? dreq_q : !dreq_q;

    assign tc_flag  = tc_q;
    assign ovr_flag = ovr_q;
    assign udr_flag = udr_q;

    // ------------------------------------------------------------------
    // FIFO storage (contents are not reset; emptiness comes from count_q)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        logic [7:0] entry_q;

        always_ff @(posedge CLK) begin
            if (fifo_wr && (wr_ptr_q == PW'(gi))) begin
                entry_q <= wr_data;
            end
        end

        assign mem_rd[gi] = entry_q;
    end

    assign head = mem_rd[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Flags and stop request
    // ------------------------------------------------------------------
    always_comb begin
        tc_d        = tc_q;
        ovr_d       = ovr_q;
        udr_d       = udr_q;
        stop_pend_d = stop_pend_q;

        if (flag_clr) begin
            tc_d  = 1'b0;
            ovr_d = 1'b0;
            udr_d = 1'b0;
        end
        // Set events override a simultaneous clear.
        if (eop_event) begin
            tc_d = 1'b1;
        end
        if (iow_done && fifo_full) begin
            ovr_d = 1'b1;
        end
        if (ior_done && fifo_empty) begin
            udr_d = 1'b1;
        end

        if (forced_eop) begin
            stop_pend_d = 1'b0;
        end
        if (stop_req) begin
            stop_pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (eop_event) begin
            state_d = S_TERM;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && ready) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (dack_act) begin
                        state_d = S_SERVICE;
                    end else if (!enable || !ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (!enable || !ready) begin
                        state_d = S_IDLE;
                    end
                end
                S_TERM: begin
                    if (flag_clr) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            dreq_q      <= 1'b0;
            dir_q       <= 1'b1;
            ior_act_q   <= 1'b0;
            iow_act_q   <= 1'b0;
            db_lat_q    <= 8'h00;
            stop_pend_q <= 1'b0;
            tc_q        <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            // DREQ is registered from the next state so it lines up with it.
            dreq_q      <= (state_d == S_REQ) || (state_d == S_SERVICE);
            if (state_q == S_IDLE) begin
                dir_q <= dir;
            end
            ior_act_q   <= !IOR_N && dack_act;
            iow_act_q   <= !IOW_N && dack_act;
            // Keep the bus value from the last acknowledged low cycle of IOW_N.
            if (!IOW_N && dack_act) begin
                db_lat_q <= DB_IN;
            end
            stop_pend_q <= stop_pend_d;
            tc_q        <= tc_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_dma_peripheral_port.sv
// -----------------------------------------------------------------------------
// tb_dma_peripheral_port
//
// Self-checking bench for dma_peripheral_port with default parameters
// (FIFO_DEPTH=4, DREQ active high, DACK active low). A byte queue models
// the FIFO contents: bytes are queued when they are pushed or written, and
// each byte the DUT returns on DB_OUT or pop_data is compared with the head
// of the queue.
// -----------------------------------------------------------------------------
module tb_dma_peripheral_port;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       DREQ;
    logic       DACK;
    logic       IOR_N;
    logic       IOW_N;
    logic       EOP_N_IN;
    logic       EOP_N_OUT;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic       DB_OE;
    logic       enable;
    logic       dir;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pop_ready;
    logic       stop_req;
    logic       tc_flag;
    logic       ovr_flag;
    logic       udr_flag;
    logic       flag_clr;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       stop_pend_m = 1'b0;

    always #5 CLK = ~CLK;

    dma_peripheral_port dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DREQ       (DREQ),
        .DACK       (DACK),
        .IOR_N      (IOR_N),
        .IOW_N      (IOW_N),
        .EOP_N_IN   (EOP_N_IN),
        .EOP_N_OUT  (EOP_N_OUT),
        .DB_IN      (DB_IN),
        .DB_OUT     (DB_OUT),
        .DB_OE      (DB_OE),
        .enable     (enable),
        .dir        (dir),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .stop_req   (stop_req),
        .tc_flag    (tc_flag),
        .ovr_flag   (ovr_flag),
        .udr_flag   (udr_flag),
        .flag_clr   (flag_clr)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_dreq(input logic lvl, input int max_cyc, input string tag);
        int n = 0;
        while (DREQ !== lvl && n < max_cyc) begin
            tick();
            n++;
        end
        check_val(tag, 8'(DREQ), 8'(lvl));
    endtask

    task automatic push_byte(input logic [7:0] b);
        check_val("push_ready", 8'(push_ready), 8'd1);
        push_valid = 1'b1;
        push_data  = b;
        tick();
        push_valid = 1'b0;
        exp_q.push_back(b);
        $display("txn push 0x%02h", b);
    endtask

    task automatic local_pop();
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        check_val("pop_valid", 8'(pop_valid), 8'd1);
        check_val("pop_data", pop_data, e);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        $display("txn pop 0x%02h", pop_data);
    endtask

    // IOR strobe with DACK already active; the bus is checked on every low cycle.
    task automatic ior_strobe(input int n_low);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        IOR_N = 1'b0;
        for (int i = 0; i < n_low; i++) begin
            #1;
            check_val("ior_db_oe", 8'(DB_OE), 8'd1);
            check_val("ior_db_out", DB_OUT, e);
            check_val("ior_eop_out", 8'(EOP_N_OUT), 8'(!stop_pend_m));
            tick();
        end
        IOR_N = 1'b1;
        tick();
        check_val("ior_db_oe_off", 8'(DB_OE), 8'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        stop_pend_m = 1'b0;
        $display("txn ior 0x%02h", e);
    endtask

    // IOW strobe of two low cycles with DACK already active; DB_IN is changed
    // after the strobe rises, so the byte must come from the low phase.
    task automatic iow_strobe(input logic [7:0] b, input logic eop);
        DB_IN    = b;
        IOW_N    = 1'b0;
        EOP_N_IN = !eop;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("iow_db_oe", 8'(DB_OE), 8'd0);
            check_val("iow_eop_out", 8'(EOP_N_OUT), 8'(!stop_pend_m));
            tick();
        end
        IOW_N    = 1'b1;
        EOP_N_IN = 1'b1;
        DB_IN    = 8'hFF;
        tick();
        if (exp_q.size() < 4) exp_q.push_back(b);
        stop_pend_m = 1'b0;
        $display("txn iow 0x%02h", b);
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    initial begin
        RESET      = 1'b0;
        DACK       = 1'b1;
        IOR_N      = 1'b1;
        IOW_N      = 1'b1;
        EOP_N_IN   = 1'b1;
        DB_IN      = 8'h00;
        enable     = 1'b0;
        dir        = 1'b1;
        push_valid = 1'b0;
        push_data  = 8'h00;
        pop_ready  = 1'b0;
        stop_req   = 1'b0;
        flag_clr   = 1'b0;

        repeat (3) tick();
        check_val("rst_dreq", 8'(DREQ), 8'd0);
        check_val("rst_db_oe", 8'(DB_OE), 8'd0);
        check_val("rst_db_out", DB_OUT, 8'h00);
        check_val("rst_eop_out", 8'(EOP_N_OUT), 8'd1);
        check_val("rst_flags", {5'd0, tc_flag, ovr_flag, udr_flag}, 8'd0);
        check_val("rst_push_ready", 8'(push_ready), 8'd1);
        check_val("rst_pop_valid", 8'(pop_valid), 8'd0);
        RESET = 1'b1;
        tick();

        // Device-to-memory single byte.
        push_byte(8'hA5);
        enable = 1'b1;
        wait_dreq(1'b1, 2, "s1_dreq_up");
        DACK = 1'b0;
        ior_strobe(2);
        wait_dreq(1'b0, 3, "s1_dreq_down");
        check_val("s1_udr_clear", 8'(udr_flag), 8'd0);
        ior_strobe(1);
        check_val("s1_empty_udr", 8'(udr_flag), 8'd1);
        DACK = 1'b1;
        pulse_clr();
        check_val("s1_udr_cleared", 8'(udr_flag), 8'd0);

        // Memory-to-device write.
        enable = 1'b0;
        dir    = 1'b0;
        tick();
        check_val("s2_push_ready", 8'(push_ready), 8'd0);
        check_val("s2_pop_valid0", 8'(pop_valid), 8'd0);
        enable = 1'b1;
        wait_dreq(1'b1, 3, "s2_dreq_up");
        DACK = 1'b0;
        iow_strobe(8'h3C, 1'b0);
        check_val("s2_pop_valid", 8'(pop_valid), 8'd1);
        check_val("s2_pop_data", pop_data, 8'h3C);

        // Fill to full, then overrun.
        iow_strobe(8'h11, 1'b0);
        iow_strobe(8'h22, 1'b0);
        iow_strobe(8'h33, 1'b0);
        wait_dreq(1'b0, 3, "s3_dreq_full");
        check_val("s3_ovr_clear", 8'(ovr_flag), 8'd0);
        iow_strobe(8'h44, 1'b0);
        check_val("s3_ovr_set", 8'(ovr_flag), 8'd1);
        check_val("s3_dreq_low", 8'(DREQ), 8'd0);
        DACK   = 1'b1;
        enable = 1'b0;
        tick();
        while (exp_q.size() > 0) local_pop();
        check_val("s3_drained", 8'(pop_valid), 8'd0);
        pulse_clr();
        check_val("s3_ovr_cleared", 8'(ovr_flag), 8'd0);

        // Controller EOP during a write.
        enable = 1'b1;
        wait_dreq(1'b1, 3, "s4_dreq_up");
        DACK = 1'b0;
        iow_strobe(8'h5A, 1'b1);
        check_val("s4_tc_set", 8'(tc_flag), 8'd1);
        for (int i = 0; i < 3; i++) begin
            check_val("s4_term_dreq", 8'(DREQ), 8'd0);
            tick();
        end
        DACK = 1'b1;
        pulse_clr();
        check_val("s4_tc_cleared", 8'(tc_flag), 8'd0);
        wait_dreq(1'b1, 3, "s4_dreq_after_clr");
        enable = 1'b0;
        wait_dreq(1'b0, 3, "s4_dreq_down");
        local_pop();
        check_val("s4_drained", 8'(pop_valid), 8'd0);

        // Device-forced EOP on a read.
        dir = 1'b1;
        tick();
        push_byte(8'h77);
        push_byte(8'h88);
        enable = 1'b1;
        wait_dreq(1'b1, 3, "s5_dreq_up");
        stop_req = 1'b1;
        tick();
        stop_req    = 1'b0;
        stop_pend_m = 1'b1;
        DACK = 1'b0;
        ior_strobe(1);
        check_val("s5_tc_set", 8'(tc_flag), 8'd1);
        check_val("s5_term_dreq", 8'(DREQ), 8'd0);
        check_val("s5_eop_released", 8'(EOP_N_OUT), 8'd1);
        DACK   = 1'b1;
        enable = 1'b0;
        pulse_clr();
        check_val("s5_tc_cleared", 8'(tc_flag), 8'd0);

        // Reset in the middle of a read with three bytes queued.
        push_byte(8'h99);
        push_byte(8'hAA);
        enable = 1'b1;
        wait_dreq(1'b1, 3, "s6_dreq_up");
        DACK  = 1'b0;
        IOR_N = 1'b0;
        #1;
        check_val("s6_pre_db_oe", 8'(DB_OE), 8'd1);
        check_val("s6_pre_db_out", DB_OUT, 8'h88);
        #2;
        RESET = 1'b0;
        #1;
        check_val("s6_rst_db_oe", 8'(DB_OE), 8'd0);
        check_val("s6_rst_db_out", DB_OUT, 8'h00);
        check_val("s6_rst_dreq", 8'(DREQ), 8'd0);
        check_val("s6_rst_eop_out", 8'(EOP_N_OUT), 8'd1);
        exp_q.delete();
        stop_pend_m = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        check_val("s6_post_db_oe", 8'(DB_OE), 8'd1);
        check_val("s6_post_db_out_empty", DB_OUT, 8'h00);
        tick();
        IOR_N = 1'b1;
        tick();
        check_val("s6_post_udr", 8'(udr_flag), 8'd1);
        check_val("s6_post_dreq", 8'(DREQ), 8'd0);
        DACK = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
